// File: rtl/cache_ctrl.sv
// cache_ctrl: sequences CPU word requests onto a direct-mapped cache with
// dirty write-back and 4-word line refill from backing memory.
module cache_ctrl #(
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 5,
  parameter int INDEX_W = 4,
  parameter int WORD_W  = 2,
  parameter int ADDR_W  = TAG_W + INDEX_W + WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_wr,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ready,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               c_enable,
  output logic               c_cmp,
  output logic               c_write,
  output logic [INDEX_W-1:0] c_index,
  output logic [WORD_W-1:0]  c_word,
  output logic [TAG_W-1:0]   c_tag,
  output logic [DATA_W-1:0]  c_data_in,
  output logic               c_valid_in,
  output logic               c_rst,
  input  logic               c_hit,
  input  logic               c_dirty,
  input  logic               c_valid,
  input  logic [TAG_W-1:0]   c_tag_out,
  input  logic [DATA_W-1:0]  c_data_out,
  input  logic               c_ack,
  output logic               mem_req,
  output logic               mem_wr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
);
  typedef enum logic [2:0] {
    INIT, IDLE, COMPARE, WB_READ, WB_MEM, REFILL_MEM, REFILL_WR, RESPOND
  } state_t;
  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [TAG_W-1:0]    vtag_q, vtag_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;
  logic                retry_q, retry_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [WORD_W-1:0]   req_word;
  assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx   = addr_q[WORD_W +: INDEX_W];
  assign req_word  = addr_q[WORD_W-1:0];
  assign cpu_rdata = rdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    vtag_d     = vtag_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    cpu_ready  = 1'b0;
    c_enable   = 1'b0;
    c_cmp      = 1'b0;
    c_write    = 1'b0;
    c_index    = req_idx;
    c_word     = req_word;
    c_tag      = req_tag;
    c_data_in  = wdata_q;
    c_valid_in = 1'b0;
    c_rst      = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = {req_tag, req_idx, cnt_q};
    mem_wdata  = buf_q;
    case (state_q)
      INIT: begin
        c_rst    = 1'b1;
        c_enable = 1'b1;
        state_d  = c_ack ? IDLE : INIT;
      end
      IDLE: if (cpu_req) begin
        wr_d    = cpu_wr;
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
        retry_d = 1'b0;
        state_d = COMPARE;
      end
      COMPARE: begin
        c_enable = 1'b1;
        c_cmp    = 1'b1;
        c_write  = wr_q;
        if (c_hit) begin
          rdata_d   = wr_q ? '0 : c_data_out;
          // the post-refill retry hit belongs to the miss already counted
          hit_cnt_d = (retry_q || hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
          state_d   = RESPOND;
        end else begin
          miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
          vtag_d     = c_tag_out;
          cnt_d      = '0;
          state_d    = (c_valid && c_dirty) ? WB_READ : REFILL_MEM;
        end
      end
      WB_READ: begin
        c_enable = 1'b1;
        c_word   = cnt_q;
        buf_d    = c_data_out;
        state_d  = WB_MEM;
      end
      WB_MEM: begin
        mem_req  = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = {vtag_q, req_idx, cnt_q};
        if (mem_ack) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (&cnt_q) ? REFILL_MEM : WB_READ;
        end
      end
      REFILL_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          buf_d   = mem_rdata;
          state_d = REFILL_WR;
        end
      end
      REFILL_WR: begin
        c_enable   = 1'b1;
        c_write    = 1'b1;
        c_word     = cnt_q;
        c_valid_in = 1'b1;
        c_data_in  = buf_q;
        cnt_d      = cnt_q + 1'b1;
        retry_d    = &cnt_q;
        state_d    = (&cnt_q) ? COMPARE : REFILL_MEM;
      end
      RESPOND: begin
        cpu_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      vtag_q     <= '0;
      buf_q      <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      vtag_q     <= vtag_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
endmodule
